// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with shared 32-step datapath
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0]   ONE_W   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_DW  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d;   // product/quotient needs negation
  logic              neg_rem_q, neg_rem_d;   // dividend was negative
  logic [XLEN-1:0]   mcand_q, mcand_d;       // multiplicand or divisor magnitude
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;           // {hi, lo} product, or {rem, quot}
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode: signedness, magnitudes and fast-path detection
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_val;
  always_comb begin
    is_div   = funct3[2];
    sgn_a    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b    = is_div ? ~funct3[0] : ~funct3[1];
    neg_a    = sgn_a & opa[XLEN-1];
    neg_b    = sgn_b & opb[XLEN-1];
    mag_a    = neg_a ? (~opa + ONE_W) : opa;
    mag_b    = neg_b ? (~opb + ONE_W) : opb;
    div_zero = (opb == '0);
    div_ovf  = ~funct3[0] & (opa == INT_MIN) & (opb == '1);
    fast     = is_div & (div_zero | div_ovf);
    if (div_zero) fast_val = funct3[1] ? opa : '1;
    else          fast_val = funct3[1] ? '0 : INT_MIN;
  end

  // One iteration of shift-add multiply and of restoring division
  logic [XLEN:0]     madd;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rshift;
  logic [XLEN+1:0]   rdiff;
  logic [2*XLEN-1:0] div_next;
  always_comb begin
    madd     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {madd, acc_q[XLEN-1:1]};
    rshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rdiff    = {1'b0, rshift} - {2'b00, mcand_q};
    if (rdiff[XLEN+1]) div_next = {rshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else               div_next = {rdiff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection applied in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem, fix_val;
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + ONE_DW) : acc_q;
    quot     = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (!op_q[2])
      fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (!op_q[1])
      fix_val = neg_res_q ? (~quot + ONE_W) : quot;
    else
      fix_val = neg_rem_q ? (~rem + ONE_W) : rem;
  end

  // Next-state logic; flush overrides everything and leaves result untouched
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          op_d      = funct3;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          mcand_d   = is_div ? mag_b : mag_a;
          acc_d     = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          if (fast) begin
            result_d = fast_val;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign busy   = ~rst & (((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX));
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opa, opb;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int ncmp = 0;
  int nerr = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .opa(opa), .opb(opb), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle 0 and follow it to done, checking busy each cycle
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int dcyc;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; funct3 = f; opa = a; opb = b;
    #1;
    busy_ok = (busy === 1'b1);
    dcyc = -1;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (busy !== ((c < lat) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (done === 1'b1) dcyc = c;
    end
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " done_cycle"}, dcyc, lat);
    chk({tag, " result"}, result, exp);
  endtask

  initial begin
    logic no_done;
    rst = 1'b1; start = 1'b1; funct3 = 3'b000; opa = 32'd5; opb = 32'd6; flush = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    run_op("MUL 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("REM -7%2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("DIVU 7/2",       3'b101, 32'd7,        32'd2,        32'd3,        34);
    run_op("REMU 7%2",       3'b111, 32'd7,        32'd2,        32'd1,        34);

    // Flush a DIV in cycle 10
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; opa = 32'd100; opb = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, 32'd1);
    no_done = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0) no_done = 1'b0;
    end
    chk("flush no_done", {31'd0, no_done}, 32'd1);
    run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    run_op("DIV 5/0",        3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM 5/0",        3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; opa = 32'd100; opb = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("REMU 100%7",     3'b111, 32'd100,      32'd7,        32'd2,        34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
